// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor computing in_a - in_b, one bit
//               per clock, LSB first. A single full-subtractor stage is
//               evaluated each cycle. Its borrow output is registered and fed
//               back as the next cycle's borrow input.
// Ports       : clk        - clock, rising-edge active
//               rst_n      - asynchronous active-low reset
//               start      - request a subtraction (sampled only when idle)
//               in_a/in_b  - minuend / subtrahend, captured on accept
//               busy       - high while a subtraction is in progress
//               done       - one-cycle pulse after the result is written
//               difference - in_a - in_b modulo 2^WIDTH
//               borrow_out - final borrow (in_a < in_b unsigned)
//               overflow   - signed overflow of the subtraction
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int                 c_CNT_W   = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    localparam logic [0:0]         c_ST_IDLE = 1'b0;
    localparam logic [0:0]         c_ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_res_sh;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;

    logic               r_done;
    logic [WIDTH-1:0]   r_difference;
    logic               r_borrow_out;
    logic               r_overflow;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic               w_a;
    logic               w_b;
    logic               w_d;
    logic               w_bout;
    logic [WIDTH-1:0]   w_res_full;

    // ------------------------------------------------------------------
    // Full-subtractor stage on the current LSBs and the fed-back borrow
    // ------------------------------------------------------------------
    assign w_a    = r_a_sh[0];
    assign w_b    = r_b_sh[0];
    assign w_d    = w_a ^ w_b ^ r_borrow;
    assign w_bout = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);

    // The new bit enters from the MSB side; on the final step this is the
    // complete result with every earlier bit already shifted down.
    assign w_res_full = {w_d, r_res_sh};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start)  w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_last) w_state_nxt = c_ST_IDLE;
            default:               w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_run    = (r_state == c_ST_RUN);
        w_accept = (r_state == c_ST_IDLE) && start;
        w_last   = w_run && (r_cnt == c_LAST);
        busy     = w_run;
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, borrow loop, counter and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res_sh     <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_difference <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a_sh   <= in_a;
                r_b_sh   <= in_b;
                r_res_sh <= '0;
                r_borrow <= 1'b0;
                r_cnt    <= '0;
            end else if (w_run) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_res_sh <= w_res_full[WIDTH-1:1];
                r_borrow <= w_bout;
                r_cnt    <= r_cnt + c_ONE;
                if (w_last) begin
                    r_difference <= w_res_full;
                    r_borrow_out <= w_bout;
                    // On the last step the shifter LSBs hold the operand MSBs.
                    r_overflow   <= (w_a ^ w_b) & (w_a ^ w_d);
                end
            end
        end
    end

    assign done       = r_done;
    assign difference = r_difference;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor. Directed vectors
//               from a table, hand-written multi-cycle corner sequences, and
//               random operands compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         busy;
    logic         done;
    logic [W-1:0] difference;
    logic         borrow_out;
    logic         overflow;

    int n_chk;
    int n_err;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t tbl [6];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_a       (in_a),
        .in_b       (in_b),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input int a, input int b,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int sa, sb, sd;
        d  = W'((a - b) & MASK);
        bo = (a < b);
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        sd = sa - sb;
        ov = (sd > ((1 << (W-1)) - 1)) || (sd < -(1 << (W-1)));
    endtask

    // Called right after a falling edge; returns right after a falling edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input string name);
        int nbusy;
        int ndone;
        start = 1'b1;
        in_a  = a;
        in_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_a  = W'($urandom);
        in_b  = W'($urandom);
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) ndone++;
        end
        chk({name, " busy_cycles"}, nbusy, W);
        chk({name, " early_done"}, ndone, 0);
        @(negedge clk);
        chk({name, " done"}, {31'd0, done}, 1);
        chk({name, " busy_at_done"}, {31'd0, busy}, 0);
        chk({name, " difference"}, {24'd0, difference}, {24'd0, ed});
        chk({name, " borrow_out"}, {31'd0, borrow_out}, {31'd0, eb});
        chk({name, " overflow"}, {31'd0, overflow}, {31'd0, eo});
        @(negedge clk);
        chk({name, " done_pulse_len"}, {31'd0, done}, 0);
    endtask

    initial begin
        logic [W-1:0] md;
        logic         mb;
        logic         mo;
        int           ndone;
        int           done_at;
        int           last_k;
        int           npulse;
        logic [W-1:0] cap_d;
        logic         idle_seen;

        tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset difference", {24'd0, difference}, 0);
        chk("reset borrow_out", {31'd0, borrow_out}, 0);
        chk("reset overflow", {31'd0, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle no start busy", {31'd0, busy}, 0);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, tbl[i].ov,
                   $sformatf("vec%0d", i));
        end

        // Start pulse and operand change mid-run are ignored
        start = 1'b1;
        in_a  = 8'h10;
        in_b  = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        in_a  = 8'hAA;
        in_b  = 8'h55;
        @(negedge clk);
        start = 1'b0;
        in_a  = 8'h33;
        ndone   = 0;
        done_at = 0;
        cap_d   = '0;
        for (int k = 5; k <= 2 * W + 4; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                done_at = k;
                cap_d   = difference;
            end
        end
        chk("ignore done_count", ndone, 1);
        chk("ignore done_cycle", done_at, W + 1);
        chk("ignore difference", {24'd0, cap_d}, 32'h0F);
        chk("ignore idle_after", {31'd0, busy}, 0);

        // Reset in the middle of a run
        start = 1'b1;
        in_a  = 8'hF0;
        in_b  = 8'h0F;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", {31'd0, busy}, 0);
        chk("midreset done", {31'd0, done}, 0);
        chk("midreset difference", {24'd0, difference}, 0);
        chk("midreset borrow_out", {31'd0, borrow_out}, 0);
        chk("midreset overflow", {31'd0, overflow}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("midreset no_activity", ndone, 0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "post_reset");

        // Back-to-back with start held high
        start  = 1'b1;
        in_a   = 8'hFF;
        in_b   = 8'h01;
        npulse = 0;
        last_k = 0;
        for (int k = 0; k < 4 * (W + 1) + 2; k++) begin
            @(posedge clk);
            #1;
            if (k > 0 && last_k == k) chk("b2b busy_restart", {31'd0, busy}, 1);
            @(negedge clk);
            if (done) begin
                npulse++;
                chk("b2b difference", {24'd0, difference}, 32'hFE);
                chk("b2b borrow_out", {31'd0, borrow_out}, 0);
                chk("b2b busy_at_done", {31'd0, busy}, 0);
                if (npulse == 1) chk("b2b first_done", k + 1, W + 1);
                else             chk("b2b gap", k + 1 - last_k, W + 1);
                last_k = k + 1;
            end
        end
        chk("b2b pulse_count", npulse, 4);
        start = 1'b0;
        idle_seen = 1'b0;
        for (int k = 0; k < 3 * W && !idle_seen; k++) begin
            @(negedge clk);
            if (!busy && !done) idle_seen = 1'b1;
        end
        chk("b2b returns_idle", {31'd0, idle_seen}, 1);

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i < 4) begin
                ra = (i[0]) ? W'(MASK) : '0;
                rb = (i[1]) ? W'(MASK) : '0;
            end
            model(int'(ra), int'(rb), md, mb, mo);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ra, rb, md, mb, mo, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
